// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: control stage in front of fetch. Decodes the current
// instruction, keeps the ALU condition flags, resolves branches and LUT jumps,
// and runs the IDLE/RUN/DONE program state machine with halt-PC capture and
// saturating cycle and taken-transfer counters.
module branch_resolve_unit #(
  parameter int I_WIDTH   = 9,
  parameter int P_WIDTH   = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [I_WIDTH-1:0]   instr,
  input  logic [P_WIDTH-1:0]   pc,
  input  logic                 flag_we,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  input  logic                 alu_carry,
  output logic                 branch_taken,
  output logic                 jump_taken,
  output logic [3:0]           branch_imm,
  output logic [5:0]           jump_target,
  output logic                 done,
  output logic [P_WIDTH-1:0]   halt_pc,
  output logic [2:0]           flags,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_BRANCH = 3'b110;
  localparam logic [2:0] OP_JUMP   = 3'b111;
  localparam logic [5:0] HALT_IDX  = 6'b111111;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t state_q, state_d;
  logic [2:0] flag_q;            // {C,N,Z}
  logic       is_branch;
  logic       is_jump_op;
  logic       is_halt;
  logic       cond_true;
  logic       in_run;
  logic       run_entry;

  // Instruction decode and branch condition against the registered flags only.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a latch behind.
    is_branch  = 1'b0;
    is_jump_op = 1'b0;
    is_halt    = 1'b0;
    cond_true  = 1'b0;
    if (instr[8:6] == OP_BRANCH) is_branch = 1'b1;
    if (instr[8:6] == OP_JUMP) begin
      if (instr[5:0] == HALT_IDX) is_halt = 1'b1;
      else                        is_jump_op = 1'b1;
    end
    case (instr[5:4])
      2'b00:   cond_true = flag_q[0];
      2'b01:   cond_true = ~flag_q[0];
      2'b10:   cond_true = flag_q[1];
      default: cond_true = flag_q[2];
    endcase
  end

  assign in_run       = (state_q == S_RUN);
  assign branch_taken = in_run & is_branch & cond_true;
  assign jump_taken   = in_run & is_jump_op;
  assign branch_imm   = instr[3:0];
  assign jump_target  = instr[5:0];
  assign done         = (state_q == S_DONE);
  assign flags        = flag_q;
  assign run_entry    = (state_q == S_IDLE) && (state_d == S_RUN);

  // Next-state logic; a raised start always wins over a HALT in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!start) state_d = S_RUN;
      S_RUN: begin
        if (start)        state_d = S_IDLE;
        else if (is_halt) state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, condition flags and halt-PC capture.
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous; it is sampled only on the clock edge,
    // and sequential state is always written with non-blocking assignments.
    if (reset) begin
      state_q <= S_IDLE;
      flag_q  <= 3'b000;
      halt_pc <= '0;
    end else begin
      state_q <= state_d;
      if (flag_we) flag_q <= {alu_carry, alu_neg, alu_zero};
      if (in_run && state_d == S_DONE) halt_pc <= pc;
    end
  end

  // Performance counters: cleared on entry to RUN, saturating, held otherwise.
  always_ff @(posedge clk) begin
    if (reset || run_entry) begin
      cycle_count <= '0;
      taken_count <= '0;
    end else if (in_run) begin
      if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
      if ((branch_taken | jump_taken) && taken_count != CNT_MAX)
        taken_count <= taken_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

  logic       clk = 1'b0;
  logic       reset, start, flag_we, alu_zero, alu_neg, alu_carry;
  logic [8:0] instr;
  logic [9:0] pc;

  logic        bt, jt, dn;
  logic [3:0]  imm;
  logic [5:0]  tgt;
  logic [9:0]  hpc;
  logic [2:0]  flg;
  logic [15:0] cyc, tkn;

  logic        s_bt, s_jt, s_dn;
  logic [3:0]  s_imm;
  logic [5:0]  s_tgt;
  logic [9:0]  s_hpc;
  logic [2:0]  s_flg;
  logic [3:0]  s_cyc, s_tkn;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
    .flag_we(flag_we), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .branch_taken(bt), .jump_taken(jt), .branch_imm(imm), .jump_target(tgt),
    .done(dn), .halt_pc(hpc), .flags(flg), .cycle_count(cyc), .taken_count(tkn)
  );

  branch_resolve_unit #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
    .flag_we(flag_we), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .branch_taken(s_bt), .jump_taken(s_jt), .branch_imm(s_imm), .jump_target(s_tgt),
    .done(s_dn), .halt_pc(s_hpc), .flags(s_flg), .cycle_count(s_cyc), .taken_count(s_tkn)
  );

  typedef enum int {
    BT, JT, IMM, TGT, DONE, HALT_PC, FLAGS, CYC, TAKEN, S_CYC, S_TAKEN, S_MISC
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [8:0] NOP   = 9'b000000000;
  localparam logic [8:0] BEQ   = 9'b110001110;
  localparam logic [8:0] BNE   = 9'b110010011;
  localparam logic [8:0] BMI   = 9'b110100101;
  localparam logic [8:0] BCS   = 9'b110110001;
  localparam logic [8:0] JMP5  = 9'b111000101;
  localparam logic [8:0] JMP3  = 9'b111000011;
  localparam logic [8:0] HALT  = 9'b111111111;

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      BT:      return {31'd0, bt};
      JT:      return {31'd0, jt};
      IMM:     return {28'd0, imm};
      TGT:     return {26'd0, tgt};
      DONE:    return {31'd0, dn};
      HALT_PC: return {22'd0, hpc};
      FLAGS:   return {29'd0, flg};
      CYC:     return {16'd0, cyc};
      TAKEN:   return {16'd0, tkn};
      S_CYC:   return {28'd0, s_cyc};
      S_TAKEN: return {28'd0, s_tkn};
      default: return {6'd0, s_bt, s_jt, s_imm, s_tgt, s_dn, s_hpc, s_flg};
    endcase
  endfunction

  // Monitor: compare every expectation queued for this cycle at the negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = sample(e.sig);
      total++;
      if (act === e.val) passed++;
      else $display("FAIL %s at %0t: got %0h expected %0h", e.sig.name(), $time, act, e.val);
    end
  end

  task automatic step(input logic rst, input logic st, input logic [8:0] ins,
                      input logic [9:0] p, input logic fwe, input logic z,
                      input logic n, input logic c);
    @(posedge clk);
    #1;
    reset = rst; start = st; instr = ins; pc = p;
    flag_we = fwe; alu_zero = z; alu_neg = n; alu_carry = c;
  endtask

  task automatic chk(input sig_e s, input logic [31:0] v);
    q.push_back('{sig: s, val: v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b1; instr = JMP3; pc = 10'd0;
    flag_we = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_carry = 1'b0;

    // Second reset cycle: everything at reset values.
    step(1, 1, JMP3, 0, 0, 0, 0, 0);
    chk(JT, 0); chk(BT, 0); chk(DONE, 0); chk(FLAGS, 0); chk(CYC, 0); chk(TAKEN, 0);
    chk(HALT_PC, 0); chk(S_MISC, 32'h0030_C000);
    // Out of reset, start held: IDLE ignores the jump. Load Z=1.
    step(0, 1, JMP3, 0, 1, 1, 0, 0);
    chk(JT, 0); chk(DONE, 0);
    // Drop start; flags now Z.
    step(0, 0, NOP, 0, 0, 0, 0, 0);
    chk(FLAGS, 3'b001); chk(BT, 0);
    // RUN 1: BEQ with Z=1 taken.
    step(0, 0, BEQ, 1, 0, 0, 0, 0);
    chk(BT, 1); chk(IMM, 4'b1110); chk(CYC, 0); chk(TAKEN, 0);
    // RUN 2: clear Z.
    step(0, 0, NOP, 2, 1, 0, 0, 0);
    chk(TAKEN, 1); chk(CYC, 1); chk(BT, 0);
    // RUN 3: BEQ with Z=0, same-cycle flag_we sets Z: not taken.
    step(0, 0, BEQ, 3, 1, 1, 0, 0);
    chk(BT, 0); chk(FLAGS, 0);
    // RUN 4: BEQ now sees Z=1.
    step(0, 0, BEQ, 4, 0, 0, 0, 0);
    chk(BT, 1); chk(TAKEN, 1);
    // RUN 5: BNE with Z=1 not taken.
    step(0, 0, BNE, 5, 0, 0, 0, 0);
    chk(BT, 0); chk(IMM, 4'b0011); chk(TAKEN, 2);
    // RUN 6: set C,N; clear Z.
    step(0, 0, NOP, 6, 1, 0, 1, 1);
    chk(BT, 0);
    // RUN 7..9: BMI, BCS, BNE all taken.
    step(0, 0, BMI, 7, 0, 0, 0, 0);
    chk(FLAGS, 3'b110); chk(BT, 1);
    step(0, 0, BCS, 8, 0, 0, 0, 0);
    chk(BT, 1); chk(TAKEN, 3);
    step(0, 0, BNE, 9, 0, 0, 0, 0);
    chk(BT, 1); chk(TAKEN, 4);
    // RUN 10: jump to LUT 5.
    step(0, 0, JMP5, 10, 0, 0, 0, 0);
    chk(JT, 1); chk(TGT, 5); chk(BT, 0); chk(TAKEN, 5);
    // RUN 11: HALT at pc 37 with a same-cycle flag write.
    step(0, 0, HALT, 37, 1, 1, 0, 0);
    chk(JT, 0); chk(BT, 0); chk(DONE, 0); chk(CYC, 10); chk(TAKEN, 6);
    // DONE: registered outputs frozen, transfers suppressed.
    step(0, 0, JMP5, 40, 0, 0, 0, 0);
    chk(DONE, 1); chk(HALT_PC, 37); chk(CYC, 11); chk(TAKEN, 6); chk(FLAGS, 3'b001); chk(JT, 0);
    step(0, 0, BEQ, 41, 0, 0, 0, 0);
    chk(DONE, 1); chk(CYC, 11); chk(BT, 0);
    // Restart: raise start in DONE.
    step(0, 1, NOP, 42, 0, 0, 0, 0);
    chk(DONE, 1);
    step(0, 1, NOP, 0, 0, 0, 0, 0);
    chk(DONE, 0); chk(CYC, 11);
    step(0, 0, NOP, 0, 0, 0, 0, 0);
    chk(DONE, 0); chk(CYC, 11);
    // New run counts from zero.
    step(0, 0, NOP, 1, 0, 0, 0, 0); chk(CYC, 0); chk(TAKEN, 0);
    step(0, 0, NOP, 2, 0, 0, 0, 0); chk(CYC, 1);
    step(0, 0, NOP, 3, 0, 0, 0, 0); chk(CYC, 2);
    step(0, 0, NOP, 4, 0, 0, 0, 0); chk(CYC, 3);
    // HALT with start high: back to IDLE, no halt capture.
    step(0, 1, HALT, 50, 0, 0, 0, 0);
    chk(CYC, 4); chk(JT, 0);
    step(0, 1, NOP, 0, 0, 0, 0, 0);
    chk(DONE, 0); chk(HALT_PC, 37); chk(CYC, 5);
    // Saturation: 20 RUN cycles of taken jumps.
    step(0, 0, NOP, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, JMP5, 10'(i), 0, 0, 0, 0);
      if (i == 15) begin
        chk(S_CYC, 15); chk(S_TAKEN, 15); chk(CYC, 15);
      end
    end
    step(0, 0, NOP, 21, 0, 0, 0, 0);
    chk(CYC, 20); chk(TAKEN, 20); chk(S_CYC, 15); chk(S_TAKEN, 15);
    // Reset mid-run.
    step(1, 0, JMP5, 22, 0, 0, 0, 0);
    chk(FLAGS, 3'b001); chk(HALT_PC, 37);
    step(0, 0, JMP5, 23, 0, 0, 0, 0);
    chk(JT, 0); chk(DONE, 0); chk(FLAGS, 0); chk(HALT_PC, 0); chk(CYC, 0); chk(TAKEN, 0);
    chk(S_CYC, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never compared (expected 0)", q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
